// File: rtl/pll_pkg.sv
// Shared types and constants for the PLL phase detector.
package pll_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StUp   = 2'b01,
    StDn   = 2'b10
  } pd_state_e;

  localparam int unsigned CntWDefault = 16;

  // Largest positive value of a signed cnt_w-bit counter.
  function automatic int unsigned sat_max(input int unsigned cnt_w);
    return (32'd1 << (cnt_w - 1)) - 32'd1;
  endfunction

  localparam int unsigned SatMaxDefault = sat_max(CntWDefault);

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous clock input and emits a registered 1-cycle pulse on each rising edge.
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  localparam int unsigned Msb = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   prev_q;
  logic                   primed_q;
  logic                   rise_q;

  // fill_q tracks which sync stages hold real samples; primed_q means prev_q does too,
  // so a level already high at reset release never looks like an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      fill_q   <= '0;
      prev_q   <= 1'b0;
      primed_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], d_i};
      fill_q   <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      prev_q   <= sync_q[Msb];
      primed_q <= fill_q[Msb];
      rise_q   <= primed_q & sync_q[Msb] & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/phase_detector.sv
// Phase-frequency detector: UP/DOWN pump pulses, signed edge-to-edge error and lock qualifier.
module phase_detector
  import pll_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = CntWDefault,
  parameter int unsigned LOCK_TOL    = 1,
  parameter int unsigned LOCK_COUNT  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    ref_in_i,
  input  logic                    fb_in_i,
  output logic                    up_o,
  output logic                    down_o,
  output logic signed [CNT_W-1:0] err_o,
  output logic                    err_valid_o,
  output logic                    lock_o
);

  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(sat_max(CNT_W));
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LockTol = CNT_W'(LOCK_TOL);
  localparam int unsigned      LockW   = $clog2(LOCK_COUNT + 1);
  localparam logic [LockW-1:0] LockMax = LockW'(LOCK_COUNT);
  localparam logic [LockW-1:0] LockOne = LockW'(1);

  logic ref_rise;
  logic fb_rise;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ref_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (ref_in_i),
    .rise_o(ref_rise)
  );

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_fb_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (fb_in_i),
    .rise_o(fb_rise)
  );

  pd_state_e               state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [CNT_W-1:0] err_q;
  logic                    err_valid_q;
  logic                    up_q, down_q;
  logic [LockW-1:0]        lock_cnt_q, lock_cnt_d;
  logic                    lock_q, lock_d;

  logic                    close;
  logic signed [CNT_W-1:0] close_err;
  logic [CNT_W-1:0]        err_mag;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    close     = 1'b0;
    close_err = '0;
    unique case (state_q)
      StIdle: begin
        if (ref_rise && fb_rise) begin
          close = 1'b1;
        end else if (ref_rise) begin
          state_d = StUp;
          cnt_d   = CntOne;
        end else if (fb_rise) begin
          state_d = StDn;
          cnt_d   = CntOne;
        end
      end
      StUp: begin
        if (fb_rise) begin
          close     = 1'b1;
          close_err = $signed(cnt_q);
          // A coincident ref edge opens the next measurement straight away.
          state_d   = ref_rise ? StUp : StIdle;
          cnt_d     = CntOne;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StDn: begin
        if (ref_rise) begin
          close     = 1'b1;
          close_err = -$signed(cnt_q);
          state_d   = fb_rise ? StDn : StIdle;
          cnt_d     = CntOne;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign err_mag = close_err[CNT_W-1] ? -close_err : close_err;

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    lock_d     = lock_q;
    if (close) begin
      if (err_mag <= LockTol) begin
        if (lock_cnt_q != LockMax) begin
          lock_cnt_d = lock_cnt_q + LockOne;
        end
        lock_d = (lock_cnt_d == LockMax);
      end else begin
        lock_cnt_d = '0;
        lock_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      lock_cnt_q  <= '0;
      lock_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_valid_q <= close;
      if (close) begin
        err_q <= close_err;
      end
      up_q        <= (state_d == StUp);
      down_q      <= (state_d == StDn);
      lock_cnt_q  <= lock_cnt_d;
      lock_q      <= lock_d;
    end
  end

  assign up_o        = up_q;
  assign down_o      = down_q;
  assign err_o       = err_q;
  assign err_valid_o = err_valid_q;
  assign lock_o      = lock_q;

endmodule
